cla16_mp_seq: RTL and testbench
===============================

// Module: cla16_mp_seq
// PURPOSE
//  Multi-precision add/subtract sequencer around one cla16 instance (16-bit CLA, flags).
//  Accepts WORDS*16-bit operands and pushes one 16-bit word per clock through the shared
//  cla16, LSW first, chaining carry.
//  Accumulates result and flags; signals completion with a one-cycle done pulse.
//  Sits between the register file / bus side and the cla16 datapath.
// PARAMETERS
//  WORDS   4   number of 16-bit words per operand (>=1); operand width N = 16*WORDS
// PORTS
//  clk       in   1    single clock, rising edge
//  rst_n     in   1    asynchronous, active-low reset
//  start     in   1    request; accepted only when busy==0
//  sub       in   1    0: A+B, 1: A-B (two's complement)
//  a         in   N    operand A, sampled on the accepting edge only
//  b         in   N    operand B, sampled on the accepting edge only
//  busy      out  1    1 while words are being processed
//  done      out  1    one-cycle pulse: result/flags valid
//  result    out  N    sum/difference
//  cout      out  1    carry out of MSW (sub: 1 = no borrow)
//  sign      out  1    result[N-1]
//  zero      out  1    1 when result == 0
//  parity    out  1    ^result (1 = odd number of ones)
//  overflow  out  1    signed overflow of the N-bit operation
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, index 0, busy=0, done=0, result=0, all flags 0,
//    internal operand/carry regs 0. Takes effect immediately, also mid-RUN; the operation
//    in flight is discarded and no done is produced for it.
//  - FSM: IDLE -> RUN on start; RUN -> RUN while idx<WORDS-1; RUN -> DONE when
//    idx==WORDS-1; DONE -> RUN on start, else -> IDLE.
//  - Accept: start=1 in IDLE or DONE at edge E0 latches a, b, sub; idx<=0; carry<=sub;
//    busy<=1. start while busy=1 is ignored (no queueing, operands not re-sampled).
//  - Per RUN cycle, word i=idx: X=a[16i+:16], Y=sub ? ~b[16i+:16] : b[16i+:16],
//    cin=carry. At the edge: result[16i+:16]<=S; carry<=cla16 cout; idx<=idx+1.
//  - Word i is written at edge E(i+1). After E(WORDS): done=1 for exactly one cycle,
//    busy=0; cout, sign, zero, parity, overflow valid from the same cycle.
//  - Latency: start edge to done high = WORDS+1 edges (WORDS=4: 5).
//  - Throughput: start during the done cycle is accepted (back-to-back, no idle cycle).
//  - Outputs hold the last result until the next accepted start. result words are
//    overwritten progressively during RUN and are not valid while busy=1.
//  - Flags: overflow is cla16 Overflow of the MSW step; zero/parity cover all N bits
//    (per-word AND / XOR accumulation or direct reduction, both acceptable).
//  - Flags update only at E(WORDS); during RUN they hold the previous operation's values.
//  - WORDS=1: RUN lasts one cycle; done after 2 edges.
// CONFIGURATION
//  CLA16_MP_SAT_EN defined: on signed overflow the result is clamped. Positive overflow
//   (sign of true result +) gives 0x7FFF..FFFF; negative gives 0x8000..0000.
//   overflow flag still 1; sign/zero/parity reflect the clamped value; cout is unclamped.
//   Clamp applied when writing the MSW at E(WORDS), so result is visible with done.
//  Not defined: wrap-around (modulo 2^N) result, no clamp logic.
// TESTING  (WORDS=4, N=64)
//  1. a=0x0000_0000_0000_FFFF, b=1, sub=0 -> result 0x0000_0000_0001_0000,
//     cout 0, zero 0, overflow 0; done exactly 5 edges after start.
//  2. a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result 0, cout 1, zero 1, overflow 0, parity 0.
//  3. a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result 0x8000_0000_0000_0000, overflow 1,
//     sign 1; with CLA16_MP_SAT_EN: result 0x7FFF_FFFF_FFFF_FFFF, sign 0, overflow 1.
//  4. a=5, b=10, sub=1 -> result 0xFFFF_FFFF_FFFF_FFFB, cout 0, sign 1, overflow 0;
//     then a=10, b=5, sub=1 -> result 5, cout 1, parity 0.
//  5. start pulsed again 2 cycles into RUN with different a/b -> ignored; first result intact.
//     start during done cycle -> accepted; second done 5 edges later.
//  6. rst_n low mid-RUN (after E2) -> busy/done/result/flags 0 immediately, no done;
//     after release a new start completes normally.

Source files
------------

// File: rtl/cla16_mp_seq.sv
// Multi-precision add/subtract sequencer: WORDS x 16-bit words pushed LSW-first through one cla16.
// Optional macro CLA16_MP_SAT_EN: clamp the result to the signed range on overflow.

module cla16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        overflow
);
  always_comb begin
    logic [15:0] p, g;
    logic [3:0]  gp, gg;
    logic [4:0]  cg;
    logic        cc, c15;
    p = x ^ y;
    g = x & y;
    for (int unsigned j = 0; j < 4; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Group carries are resolved in one lookahead level; bits ripple only inside a nibble.
    cg[0] = cin;
    cg[1] = gg[0] | (gp[0] & cin);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    s   = '0;
    c15 = 1'b0;
    for (int unsigned j = 0; j < 4; j++) begin
      cc = cg[j];
      for (int unsigned k = 0; k < 4; k++) begin
        s[4*j+k] = p[4*j+k] ^ cc;
        if (4*j + k == 15) c15 = cc;
        cc = g[4*j+k] | (p[4*j+k] & cc);
      end
    end
    cout     = cg[4];
    overflow = c15 ^ cg[4];
  end
endmodule

module cla16_mp_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] result,
  output logic                cout,
  output logic                sign,
  output logic                zero,
  output logic                parity,
  output logic                overflow
);
  localparam int unsigned N  = 16 * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [N-1:0]   a_r, b_r, res_nxt;
  logic           sub_r, carry;
  logic [IW-1:0]  idx;
  logic           accept, last;
  logic [15:0]    x, yb, y, s;
  logic           co, ov;

  assign accept = start && (state != RUN);
  assign last   = (idx == IW'(WORDS - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    x  = '0;
    yb = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        x  = a_r[16*i +: 16];
        yb = b_r[16*i +: 16];
      end
    end
    y = sub_r ? ~yb : yb;
  end

  cla16 u_cla16 (
    .x        (x),
    .y        (y),
    .cin      (carry),
    .s        (s),
    .cout     (co),
    .overflow (ov)
  );

  always_comb begin
    res_nxt = result;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) res_nxt[16*i +: 16] = s;
    end
`ifdef CLA16_MP_SAT_EN
    // A wrapped MSW sign of 1 means the true result was positive.
    if (last && ov) begin
      res_nxt        = '0;
      res_nxt[N-1]   = ~s[15];
      res_nxt[N-2:0] = {(N-1){s[15]}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      sub_r    <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      sub_r <= sub;
      carry <= sub;
      idx   <= '0;
    end else if (state == RUN) begin
      result <= res_nxt;
      carry  <= co;
      idx    <= idx + 1'b1;
      if (last) begin
        cout     <= co;
        overflow <= ov;
        sign     <= res_nxt[N-1];
        zero     <= ~|res_nxt;
        parity   <= ^res_nxt;
      end
    end
  end
endmodule

// File: tb/tb_cla16_mp_seq.sv
// Scoreboard bench for cla16_mp_seq with WORDS=4 (N=64).
module tb_cla16_mp_seq;
  localparam int unsigned WORDS = 4;

  typedef struct packed {
    logic [63:0] res;
    logic        co, sg, z, par, ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        busy, done, cout, sign, zero, parity, overflow;
  logic [63:0] result;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  cla16_mp_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .sign(sign),
    .zero(zero), .parity(parity), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] aa, input logic [63:0] bb, input logic s);
    exp_t        e;
    logic [63:0] yy;
    logic [64:0] sum;
    yy    = s ? ~bb : bb;
    sum   = {1'b0, aa} + {1'b0, yy} + {64'd0, s};
    e.res = sum[63:0];
    e.co  = sum[64];
    e.ov  = (aa[63] == yy[63]) && (sum[63] != aa[63]);
`ifdef CLA16_MP_SAT_EN
    if (e.ov) e.res = aa[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    e.sg  = e.res[63];
    e.z   = (e.res == 64'd0);
    e.par = ^e.res;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      chk("done_pulse", {63'd0, prev_done}, 64'd0);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("cout", {63'd0, cout}, {63'd0, e.co});
        chk("sign", {63'd0, sign}, {63'd0, e.sg});
        chk("zero", {63'd0, zero}, {63'd0, e.z});
        chk("parity", {63'd0, parity}, {63'd0, e.par});
        chk("overflow", {63'd0, overflow}, {63'd0, e.ov});
      end
    end
    prev_done = done;
  end

  // Returns at the accepting edge + 1.
  task automatic start_op(input logic [63:0] aa, input logic [63:0] bb, input logic s);
    @(negedge clk);
    start = 1'b1; a = aa; b = bb; sub = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(aa, bb, s));
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Edges counted inclusive of the accepting edge; caller is at that edge + 1.
  task automatic wait_done(input bit check_lat);
    int edges = 1;
    while (!done && edges <= 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    else if (check_lat) chk("latency", 64'(edges), 64'(WORDS + 1));
  endtask

  initial begin
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {59'd0, cout, sign, zero, parity, overflow}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0); wait_done(1'b1);
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0); wait_done(1'b1);
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0); wait_done(1'b1);
    start_op(64'h8000_0000_0000_0000, 64'd1, 1'b1); wait_done(1'b1);
    start_op(64'd5, 64'd10, 1'b1); wait_done(1'b1);
    start_op(64'd10, 64'd5, 1'b1); wait_done(1'b1);

    // Start while busy must be ignored.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; a = 64'hDEAD_BEEF_0000_0001; b = 64'h1111; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0);

    // Back-to-back: accepted in the done cycle.
    start_op(64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAB, 1'b0);
    wait_done(1'b1);

    for (int i = 0; i < 8; i++) begin
      start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_done(1'b1);
    end

    // Asynchronous reset mid-RUN.
    start_op(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_flags", {59'd0, cout, sign, zero, parity, overflow}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int cnt = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (done) cnt++;
      end
      chk("no_done_after_rst", 64'(cnt), 64'd0);
    end
    start_op(64'h0000_0000_0001_0000, 64'd1, 1'b1);
    wait_done(1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
